// File: rtl/detect_mult_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | detect_mult_ctrl                                                        |
// | Settles/locks the input latch, runs a shift-add multiply, publishes it. |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module detect_mult_ctrl #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 changed,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 locked,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   result,
    output logic                 valid,
    output logic                 stale
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_LOCK   = 3'd2;
    localparam logic [2:0] S_CALC   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int CNT_W  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int STEP_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(WIDTH - 1);

    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic                 w_lock_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [STEP_W-1:0]    r_step;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic                 r_seen;

    // locked follows the next state so it is already high in the cycle LOCK is entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            locked  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            locked  <= w_lock_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (changed) w_state_next = S_SETTLE;
            S_SETTLE: if (!changed && (r_cnt == CNT_LAST)) w_state_next = S_LOCK;
            S_LOCK:   w_state_next = S_CALC;
            S_CALC:   if (r_step == STEP_LAST) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
        w_lock_next = (w_state_next == S_LOCK) || (w_state_next == S_CALC) ||
                      (w_state_next == S_DONE);
    end

    always_comb begin
        busy  = (r_state != S_IDLE);
        valid = (r_state == S_DONE);
    end

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_step   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_seen   <= 1'b0;
            result   <= '0;
            stale    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (changed) r_cnt <= '0;
                end
                S_SETTLE: begin
                    if (changed) r_cnt <= '0;
                    else         r_cnt <= r_cnt + 1'b1;
                end
                S_LOCK: begin
                    r_mcand  <= {{WIDTH{1'b0}}, a_in};
                    r_mplier <= b_in;
                    r_acc    <= '0;
                    r_step   <= '0;
                    r_seen   <= changed;
                end
                S_CALC: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_step   <= r_step + 1'b1;
                    r_seen   <= r_seen | changed;
                    // a change in the final step still counts toward stale
                    if (r_step == STEP_LAST) begin
                        result <= w_acc_next;
                        stale  <= r_seen | changed;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_detect_mult_ctrl.sv
`default_nettype none
// Directed bench for detect_mult_ctrl with a behavioural input latch in front of each instance.
module tb_detect_mult_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // default configuration
    logic [7:0]  a_live = 8'h00, b_live = 8'h00;
    logic [7:0]  a_lat  = 8'h00, b_lat  = 8'h00;
    logic        changed, locked, busy, valid, stale;
    logic [15:0] result;

    assign changed = (a_live != a_lat) || (b_live != b_lat);
    always @(posedge clk) if (!locked) begin a_lat <= a_live; b_lat <= b_live; end

    detect_mult_ctrl dut (
        .clk(clk), .rst(rst), .changed(changed), .a_in(a_lat), .b_in(b_lat),
        .locked(locked), .busy(busy), .result(result), .valid(valid), .stale(stale)
    );

    // small configuration: WIDTH=4, STABLE_CYCLES=1
    logic [3:0]  a4_live = 4'h0, b4_live = 4'h0;
    logic [3:0]  a4_lat  = 4'h0, b4_lat  = 4'h0;
    logic        changed4, locked4, busy4, valid4, stale4;
    logic [7:0]  result4;

    assign changed4 = (a4_live != a4_lat) || (b4_live != b4_lat);
    always @(posedge clk) if (!locked4) begin a4_lat <= a4_live; b4_lat <= b4_live; end

    detect_mult_ctrl #(.WIDTH(4), .STABLE_CYCLES(1)) dut4 (
        .clk(clk), .rst(rst), .changed(changed4), .a_in(a4_lat), .b_in(b4_lat),
        .locked(locked4), .busy(busy4), .result(result4), .valid(valid4), .stale(stale4)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic test_reset();
        #2;
        total_cnt++;
        if ({locked, busy, valid, stale} !== 4'b0000) $display("FAIL reset_flags: got %b expected 0000", {locked, busy, valid, stale});
        else pass_cnt++;
        total_cnt++;
        if (result !== 16'h0000) $display("FAIL reset_result: got %h expected 0000", result);
        else pass_cnt++;
        total_cnt++;
        if ({locked4, busy4, valid4, stale4, result4} !== 12'h000) $display("FAIL reset_dut4: got %h expected 000", {locked4, busy4, valid4, stale4, result4});
        else pass_cnt++;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL idle_after_reset: got %b expected 0", busy);
        else pass_cnt++;
    endtask

    // Apply operands from idle/settle and watch the whole transaction over 20 edges.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_res, input logic exp_stale, input string name);
        int lock_e, done_e, nvalid;
        logic [15:0] res;
        logic        stl;
        lock_e = -1; done_e = -1; nvalid = 0; res = 'x; stl = 1'bx;
        @(negedge clk); a_live = a; b_live = b;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (locked && lock_e < 0) lock_e = n;
            if (valid) begin
                nvalid++;
                if (done_e < 0) begin done_e = n; res = result; stl = stale; end
            end
        end
        total_cnt++;
        if (lock_e !== 4) $display("FAIL %s lock_edge: got %0d expected 4", name, lock_e);
        else pass_cnt++;
        total_cnt++;
        if (done_e !== 13) $display("FAIL %s done_edge: got %0d expected 13", name, done_e);
        else pass_cnt++;
        total_cnt++;
        if (res !== exp_res) $display("FAIL %s result: got %h expected %h", name, res, exp_res);
        else pass_cnt++;
        total_cnt++;
        if (stl !== exp_stale) $display("FAIL %s stale: got %b expected %b", name, stl, exp_stale);
        else pass_cnt++;
        total_cnt++;
        if (nvalid !== 1) $display("FAIL %s valid_count: got %0d expected 1", name, nvalid);
        else pass_cnt++;
        total_cnt++;
        if ({locked, busy, result} !== {2'b00, exp_res}) $display("FAIL %s after_done: got %b_%b_%h expected 0_0_%h", name, locked, busy, result, exp_res);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        run_op(8'h0C, 8'h0A, 16'h0078, 1'b0, "basic");
    endtask

    task automatic test_patterns();
        run_op(8'hFF, 8'hFF, 16'hFE01, 1'b0, "max_operands");
        run_op(8'h00, 8'h37, 16'h0000, 1'b0, "zero_operand");
    endtask

    task automatic test_toggle();
        logic lock_seen;
        lock_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_live = (i % 2 == 1) ? 8'h22 : 8'h11;
            b_live = 8'h03;
            repeat (2) begin @(posedge clk); #1; if (locked) lock_seen = 1'b1; end
        end
        total_cnt++;
        if (lock_seen !== 1'b0) $display("FAIL toggle_no_lock: got %b expected 0", lock_seen);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL toggle_settling: got %b expected 1", busy);
        else pass_cnt++;
        run_op(8'h05, 8'h03, 16'h000F, 1'b0, "after_toggle");
    endtask

    task automatic test_stale();
        int v1_e, v2_e, nvalid;
        logic [15:0] r1, r2;
        logic s1, s2, lk14;
        v1_e = -1; v2_e = -1; nvalid = 0; r1 = 'x; r2 = 'x; s1 = 1'bx; s2 = 1'bx; lk14 = 1'bx;
        @(negedge clk); a_live = 8'h02; b_live = 8'h04;
        for (int n = 0; n < 35; n++) begin
            @(posedge clk); #1;
            if (n == 8) a_live = 8'h09;
            if (n == 14) lk14 = locked;
            if (valid) begin
                nvalid++;
                if (v1_e < 0) begin v1_e = n; r1 = result; s1 = stale; end
                else if (v2_e < 0) begin v2_e = n; r2 = result; s2 = stale; end
            end
        end
        total_cnt++;
        if (v1_e !== 13) $display("FAIL stale_first_edge: got %0d expected 13", v1_e);
        else pass_cnt++;
        total_cnt++;
        if ({r1, s1} !== {16'h0008, 1'b1}) $display("FAIL stale_first: got %h/%b expected 0008/1", r1, s1);
        else pass_cnt++;
        total_cnt++;
        if (lk14 !== 1'b0) $display("FAIL stale_release: got %b expected 0", lk14);
        else pass_cnt++;
        total_cnt++;
        if (v2_e !== 28) $display("FAIL stale_second_edge: got %0d expected 28", v2_e);
        else pass_cnt++;
        total_cnt++;
        if ({r2, s2} !== {16'h0024, 1'b0}) $display("FAIL stale_second: got %h/%b expected 0024/0", r2, s2);
        else pass_cnt++;
        total_cnt++;
        if (nvalid !== 2) $display("FAIL stale_valid_count: got %0d expected 2", nvalid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic busy9;
        @(negedge clk); a_live = 8'h07; b_live = 8'h06;
        for (int n = 0; n < 10; n++) begin @(posedge clk); #1; end
        busy9 = busy;
        total_cnt++;
        if ({busy9, locked} !== 2'b11) $display("FAIL mid_calc_active: got %b expected 11", {busy9, locked});
        else pass_cnt++;
        @(negedge clk); rst = 1'b0; #1;
        total_cnt++;
        if ({locked, busy, valid, stale, result} !== 20'h00000) $display("FAIL async_abort: got %h expected 00000", {locked, busy, valid, stale, result});
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({locked, busy, valid} !== 3'b000) $display("FAIL abort_hold: got %b expected 000", {locked, busy, valid});
        else pass_cnt++;
        @(negedge clk); rst = 1'b1;
        run_op(8'h03, 8'h05, 16'h000F, 1'b0, "after_abort");
    endtask

    task automatic test_small_config();
        int lock_e, done_e, nvalid;
        logic [7:0] res;
        lock_e = -1; done_e = -1; nvalid = 0; res = 'x;
        @(negedge clk); a4_live = 4'hF; b4_live = 4'hF;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (locked4 && lock_e < 0) lock_e = n;
            if (valid4) begin
                nvalid++;
                if (done_e < 0) begin done_e = n; res = result4; end
            end
        end
        total_cnt++;
        if (lock_e !== 1) $display("FAIL small_lock_edge: got %0d expected 1", lock_e);
        else pass_cnt++;
        total_cnt++;
        if (done_e !== 6) $display("FAIL small_done_edge: got %0d expected 6", done_e);
        else pass_cnt++;
        total_cnt++;
        if (res !== 8'hE1) $display("FAIL small_result: got %h expected e1", res);
        else pass_cnt++;
        total_cnt++;
        if (nvalid !== 1) $display("FAIL small_valid_count: got %0d expected 1", nvalid);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_toggle();
        test_stale();
        test_reset_mid();
        test_small_config();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
